bnn_window_conv: RTL and testbench

- Downstream consumer of conv_single_slide's packed K*K window.
- Computes a binary-weight (+1/-1) signed sum of the window for each of NUM_OC output channels, one channel per cycle.
- Thresholds each sum (folded batch-norm plus sign) into one output bit per channel.
- Emits the NUM_OC-bit activation vector to the next BNN layer over a valid/ready handshake.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/bnn_xnor_sum.sv | 39 +++
 rtl/bnn_window_conv.sv | 120 ++++++++++++
 tb/tb_bnn_window_conv.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// ============================================================================
//  Module      : bnn_pkg
//  Description : Shared types and helpers for the binary-weight window conv.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Signed width able to hold +/- K*K*(2^DATA_WIDTH-1) without overflow.
    function automatic int acc_width(input int data_width, input int k);
        return data_width + $clog2(k * k) + 1;
    endfunction

    function automatic int elem_lsb(input int idx, input int data_width);
        return idx * data_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_xnor_sum.sv
// ============================================================================
//  Module      : bnn_xnor_sum
//  Description : Combinational +1/-1 weighted signed sum of one K*K window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_xnor_sum
    import bnn_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int K          = 3,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K)
) (
    input  logic [K*K*DATA_WIDTH-1:0]   i_window,
    input  logic [K*K-1:0]              i_weights,
    output logic signed [ACC_WIDTH-1:0] o_sum
);

    localparam int c_NUM_ELEM = K * K;

    logic signed [ACC_WIDTH-1:0] w_acc;
    logic signed [ACC_WIDTH-1:0] w_elem;

    always_comb begin
        w_acc  = '0;
        w_elem = '0;
        for (int i = 0; i < c_NUM_ELEM; i++) begin
            w_elem = {{(ACC_WIDTH-DATA_WIDTH){1'b0}},
                      i_window[elem_lsb(i, DATA_WIDTH) +: DATA_WIDTH]};
            w_acc  = i_weights[i] ? (w_acc + w_elem) : (w_acc - w_elem);
        end
    end

    assign o_sum = w_acc;

endmodule

`default_nettype wire

// File: rtl/bnn_window_conv.sv
// ============================================================================
//  Module      : bnn_window_conv
//  Description : Per-channel binary-weight conv + threshold over one window,
//                one output channel per cycle, valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_window_conv
    import bnn_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int K          = 3,
    parameter int NUM_OC     = 4,
    // Derived from DATA_WIDTH and K; leave at its default.
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ivalid,
    input  logic [K*K*DATA_WIDTH-1:0]   idata,
    output logic                        iready,
    input  logic                        w_load,
    input  logic [$clog2(NUM_OC)-1:0]   w_addr,
    input  logic [K*K-1:0]              w_data,
    input  logic [ACC_WIDTH-1:0]        thr_data,
    output logic                        w_ready,
    output logic                        ovalid,
    output logic [NUM_OC-1:0]           odata,
    input  logic                        oready,
    output logic [7:0]                  drop_cnt
);

    localparam int c_NUM_ELEM = K * K;
    localparam int c_OC_W     = $clog2(NUM_OC);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [c_OC_W-1:0]            r_oc;
    logic [K*K*DATA_WIDTH-1:0]    r_window;
    logic [c_NUM_ELEM-1:0]        r_w   [NUM_OC];
    logic signed [ACC_WIDTH-1:0]  r_thr [NUM_OC];
    logic [NUM_OC-1:0]            r_written;
    logic [NUM_OC-1:0]            r_odata;
    logic [7:0]                   r_drop_cnt;

    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic                         w_bit;

    assign w_ready  = (r_state == IDLE);
    assign iready   = (r_state == IDLE) && (&r_written);
    assign ovalid   = (r_state == OUT);
    assign odata    = r_odata;
    assign drop_cnt = r_drop_cnt;

    bnn_xnor_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (K),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_xnor_sum (
        .i_window   (r_window),
        .i_weights  (r_w[r_oc]),
        .o_sum      (w_sum)
    );

    assign w_bit = (w_sum >= r_thr[r_oc]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ivalid && iready) w_state_nxt = COMP;
            COMP:    if (r_oc == c_OC_W'(NUM_OC - 1)) w_state_nxt = OUT;
            OUT:     if (oready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_OC; c++) begin
                r_w[c]   <= '0;
                r_thr[c] <= '0;
            end
            r_written  <= '0;
            r_window   <= '0;
            r_oc       <= '0;
            r_odata    <= '0;
            r_drop_cnt <= '0;
        end else begin
            // A write in the accept cycle lands before the first COMP read.
            if (w_load && w_ready) begin
                r_w[w_addr]       <= w_data;
                r_thr[w_addr]     <= thr_data;
                r_written[w_addr] <= 1'b1;
            end
            if (ivalid && iready) begin
                r_window <= idata;
                r_oc     <= '0;
            end
            if (r_state == COMP) begin
                r_odata[r_oc] <= w_bit;
                r_oc          <= r_oc + c_OC_W'(1);
            end
            if (ivalid && !iready && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bnn_window_conv.sv
// ============================================================================
//  Module      : tb_bnn_window_conv
//  Description : Directed self-checking bench for bnn_window_conv.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bnn_window_conv;

    localparam int c_DW    = 6;
    localparam int c_K     = 3;
    localparam int c_NOC   = 4;
    localparam int c_ACC   = 11;
    localparam int c_WIN_W = c_K * c_K * c_DW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ivalid = 1'b0;
    logic [c_WIN_W-1:0] idata = '0;
    logic               iready;
    logic               w_load = 1'b0;
    logic [1:0]         w_addr = '0;
    logic [8:0]         w_data = '0;
    logic [c_ACC-1:0]   thr_data = '0;
    logic               w_ready;
    logic               ovalid;
    logic [c_NOC-1:0]   odata;
    logic               oready = 1'b1;
    logic [7:0]         drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [c_WIN_W-1:0] win_max;
    logic [c_WIN_W-1:0] win_ramp;

    always #5 clk = ~clk;

    bnn_window_conv #(
        .DATA_WIDTH (c_DW),
        .K          (c_K),
        .NUM_OC     (c_NOC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ivalid   (ivalid),
        .idata    (idata),
        .iready   (iready),
        .w_load   (w_load),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .thr_data (thr_data),
        .w_ready  (w_ready),
        .ovalid   (ovalid),
        .odata    (odata),
        .oready   (oready),
        .drop_cnt (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load_slot(input logic [1:0] a, input logic [8:0] w, input logic [c_ACC-1:0] t);
        w_load = 1'b1; w_addr = a; w_data = w; thr_data = t;
        tick();
        w_load = 1'b0;
    endtask

    // Accept one window, measure accept-to-ovalid latency, check the result.
    // With inj set, a slot-1 write is attempted during the first COMP cycle.
    task automatic run_window(input string tag, input logic [c_WIN_W-1:0] win,
                              input logic [3:0] exp_od, input bit inj);
        int cyc;
        chk_val({tag, "_iready"}, {31'd0, iready}, 32'd1);
        ivalid = 1'b1; idata = win;
        tick();
        ivalid = 1'b0; w_load = 1'b0;
        if (inj) begin
            w_load = 1'b1; w_addr = 2'd1; w_data = 9'h1FF; thr_data = -11'sd1000;
        end
        cyc = 0;
        while (!ovalid && cyc < 20) begin
            tick();
            w_load = 1'b0;
            cyc++;
        end
        chk_val({tag, "_latency"}, cyc, 32'd4);
        chk_val({tag, "_odata"}, {28'd0, odata}, {28'd0, exp_od});
        if (oready) begin
            tick();
            chk_val({tag, "_done"}, {31'd0, ovalid}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            win_max[i*c_DW +: c_DW]  = 6'd63;
            win_ramp[i*c_DW +: c_DW] = 6'(i);
        end

        tick(); tick();
        rst = 1'b0;
        chk_val("rst_ovalid", {31'd0, ovalid}, 32'd0);
        chk_val("rst_odata", {28'd0, odata}, 32'd0);
        chk_val("rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk_val("rst_iready", {31'd0, iready}, 32'd0);
        chk_val("rst_wready", {31'd0, w_ready}, 32'd1);

        // Partial weights: window must be dropped until slot 3 is written.
        load_slot(2'd0, 9'h1FF, 11'sd567);
        load_slot(2'd1, 9'h1FF, 11'sd568);
        load_slot(2'd2, 9'h1FF, 11'sd567);
        chk_val("partial_iready", {31'd0, iready}, 32'd0);
        ivalid = 1'b1; idata = win_max;
        tick();
        ivalid = 1'b0;
        chk_val("partial_drop", {24'd0, drop_cnt}, 32'd1);
        chk_val("partial_idle", {31'd0, w_ready}, 32'd1);
        load_slot(2'd3, 9'h1FF, 11'sd568);
        chk_val("full_iready", {31'd0, iready}, 32'd1);

        // All +1, all 63: sum 567; thr 567 -> 1, 568 -> 0.
        run_window("pos_max", win_max, 4'b0101, 1'b0);

        // All -1, all 63: sum -567.
        load_slot(2'd0, 9'h000, -11'sd567);
        load_slot(2'd1, 9'h000, -11'sd566);
        load_slot(2'd2, 9'h000, -11'sd566);
        load_slot(2'd3, 9'h000, -11'sd567);
        run_window("neg_max", win_max, 4'b1001, 1'b0);

        // Elements 0..8, odd positions +1: sum 16-20 = -4.
        load_slot(2'd0, 9'b010101010, -11'sd4);
        load_slot(2'd1, 9'b010101010, -11'sd3);
        load_slot(2'd2, 9'b010101010, -11'sd5);
        load_slot(2'd3, 9'b010101010, 11'sd0);
        run_window("ramp", win_ramp, 4'b0101, 1'b0);

        // Backpressure: result held 5 cycles, 3 windows dropped meanwhile.
        oready = 1'b0;
        run_window("bp", win_ramp, 4'b0101, 1'b0);
        for (int j = 0; j < 5; j++) begin
            chk_val("bp_ovalid", {31'd0, ovalid}, 32'd1);
            chk_val("bp_odata", {28'd0, odata}, 32'h5);
            chk_val("bp_iready", {31'd0, iready}, 32'd0);
            ivalid = (j < 3);
            tick();
            ivalid = 1'b0;
        end
        chk_val("bp_drop", {24'd0, drop_cnt}, 32'd4);
        oready = 1'b1;
        tick();
        chk_val("bp_release_ovalid", {31'd0, ovalid}, 32'd0);
        chk_val("bp_release_iready", {31'd0, iready}, 32'd1);

        // Slot-0 write in the accept cycle is used (all +1, sum 36 < 37);
        // the slot-1 write attempted during COMP must be ignored.
        w_load = 1'b1; w_addr = 2'd0; w_data = 9'h1FF; thr_data = 11'sd37;
        run_window("wr_accept", win_ramp, 4'b0100, 1'b1);
        chk_val("wr_accept_drop", {24'd0, drop_cnt}, 32'd4);
        run_window("wr_ignored", win_ramp, 4'b0100, 1'b0);

        // Reset during the 2nd COMP cycle.
        ivalid = 1'b1; idata = win_ramp;
        tick();
        ivalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_val("mid_rst_ovalid", {31'd0, ovalid}, 32'd0);
        chk_val("mid_rst_iready", {31'd0, iready}, 32'd0);
        chk_val("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk_val("mid_rst_odata", {28'd0, odata}, 32'd0);
        ivalid = 1'b1;
        tick();
        ivalid = 1'b0;
        tick(); tick(); tick(); tick();
        chk_val("post_rst_drop", {24'd0, drop_cnt}, 32'd1);
        chk_val("post_rst_ovalid", {31'd0, ovalid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
